// File: rtl/softex_pkg.sv
// Shared types and constants for the SoftEx TCDM responder.
// LFSR helpers drive the deterministic grant-stall pattern.
package softex_pkg;

    localparam int unsigned TCDM_DW = 128;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 in shift-right form sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic [TCDM_DW-1:0] data;
    } tcdm_rsp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/hci_core_intf.sv
// HCI core TCDM channel, reduced to the fields the responder uses.
// The initiator drives the request side, the target the response side.
interface hci_core_intf #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 32
) ();

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [DW-1:0]   r_data;
    logic            r_valid;
    logic            r_ready;

    modport initiator (
        output req, add, wen, be, data, r_ready,
        input  gnt, r_data, r_valid
    );

    modport target (
        input  req, add, wen, be, data, r_ready,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/softex_tcdm_rsp_buffer.sv
// Response FIFO for the TCDM responder; push and pop may coincide
// even when full, since the head is read out before being overwritten.
module softex_tcdm_rsp_buffer
    import softex_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  tcdm_rsp_t data_i,
    input  logic      pop_i,
    output tcdm_rsp_t data_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    tcdm_rsp_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = ptr_inc(wr_q);
        if (do_pop)  rd_d = ptr_inc(rd_q);
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/softex_tcdm_responder.sv
// TCDM target model: word array, LFSR/credit-gated grants, byte-enabled
// writes and in-order read responses after a fixed latency.
module softex_tcdm_responder
    import softex_pkg::*;
#(
    parameter int unsigned DW        = 128,
    parameter int unsigned AW        = 32,
    parameter int unsigned N_WORDS   = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned RSP_DEPTH = 4,
    parameter bit          STALL_EN  = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    hci_core_intf.target                   tcdm,
    output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding_o
);

    localparam int unsigned OFFS = $clog2(DW / 8);
    localparam int unsigned IW   = $clog2(N_WORDS);
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);

    logic [DW-1:0] mem_q [N_WORDS];
    logic [IW-1:0] idx;
    logic [DW-1:0] rd_word;
    logic [15:0]   lfsr_q;
    logic [CW-1:0] out_q, out_d;
    logic          stall;
    logic          rd_acc;
    logic          wr_acc;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    tcdm_rsp_t     push_rsp;
    tcdm_rsp_t     head_rsp;
    logic          unused_add;

    assign unused_add = ^tcdm.add;
    assign idx        = tcdm.add[OFFS +: IW];
    assign rd_word    = mem_q[idx];

    assign stall    = STALL_EN & lfsr_q[0];
    assign tcdm.gnt = tcdm.req & ~stall
                    & (~tcdm.wen | (out_q < CW'(RSP_DEPTH)));
    assign rd_acc   = tcdm.req & tcdm.gnt & tcdm.wen;
    assign wr_acc   = tcdm.req & tcdm.gnt & ~tcdm.wen;

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int k = 0; k < int'(DW / 8); k++) begin
                if (tcdm.be[k]) mem_q[idx][8*k +: 8] <= tcdm.data[8*k +: 8];
            end
        end
    end

    // The FIFO register is the last latency stage, so only LATENCY-1
    // pipeline registers sit in front of it.
    if (LATENCY == 1) begin : g_direct
        assign push          = rd_acc;
        assign push_rsp.data = rd_word;
    end else begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        logic [DW-1:0]      dat_q [LATENCY-1];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= rd_acc;
                for (int i = 1; i < int'(LATENCY) - 1; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            dat_q[0] <= rd_word;
            for (int i = 1; i < int'(LATENCY) - 1; i++) dat_q[i] <= dat_q[i-1];
        end

        assign push          = vld_q[LATENCY-2];
        assign push_rsp.data = dat_q[LATENCY-2];
    end

    softex_tcdm_rsp_buffer #(
        .DEPTH (RSP_DEPTH)
    ) i_rsp_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_rsp),
        .pop_i   (pop),
        .data_o  (head_rsp),
        .empty_o (empty),
        .full_o  (full)
    );

    assign tcdm.r_valid = ~empty;
    assign tcdm.r_data  = tcdm.r_valid ? head_rsp.data : '0;
    assign pop          = tcdm.r_valid & tcdm.r_ready;

    always_comb begin
        out_d = out_q;
        if (rd_acc && !pop) begin
            out_d = out_q + 1'b1;
        end else if (!rd_acc && pop) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) out_q <= '0;
        else       out_q <= out_d;
    end

    assign outstanding_o = out_q;

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Bench for softex_tcdm_responder: three configurations, a memory-model
// scoreboard on every instance plus directed latency/credit/stall sequences.
module tb_softex_tcdm_responder;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic [2:0] out_a, out_b, out_c;

    always #5 clk = ~clk;

    hci_core_intf #(.DW(128), .AW(32)) ifa ();
    hci_core_intf #(.DW(128), .AW(32)) ifb ();
    hci_core_intf #(.DW(128), .AW(32)) ifc ();

    softex_tcdm_responder #(
        .LATENCY(1), .RSP_DEPTH(4), .STALL_EN(1'b0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .tcdm(ifa), .outstanding_o(out_a)
    );

    softex_tcdm_responder #(
        .LATENCY(3), .RSP_DEPTH(4), .STALL_EN(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .tcdm(ifb), .outstanding_o(out_b)
    );

    softex_tcdm_responder #(
        .LATENCY(1), .RSP_DEPTH(4), .STALL_EN(1'b1)
    ) dut_c (
        .clk_i(clk), .rst_i(rst_c), .tcdm(ifc), .outstanding_o(out_c)
    );

    int cmp_n = 0;
    int err_n = 0;
    int rsp_n [3];

    logic [127:0] mm [3][1024];
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [127:0] q2 [$];
    logic [15:0]  ref_l;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        cmp_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sb_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int d, input logic [127:0] v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int d, output logic [127:0] v);
        case (d)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic sb_clear(input int d);
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic sb_step(input int d, input logic rst, req, gnt, wen,
                           input logic [31:0] add, input logic [15:0] be,
                           input logic [127:0] wd, input logic rv, rr,
                           input logic [127:0] rdat);
        logic [127:0] e;
        int w;
        if (rst) begin
            sb_clear(d);
            return;
        end
        if (rv && rr) begin
            rsp_n[d]++;
            if (sb_size(d) == 0) begin
                cmp_n++;
                err_n++;
                $display("FAIL sb_unexpected[%0d]: got %h, expected none", d, rdat);
            end else begin
                sb_pop(d, e);
                chk($sformatf("sb_rdata[%0d]", d), rdat, e);
            end
        end
        if (req && gnt) begin
            w = int'(add[13:4]);
            if (wen) begin
                sb_push(d, mm[d][w]);
            end else begin
                for (int k = 0; k < 16; k++) begin
                    if (be[k]) mm[d][w][8*k +: 8] = wd[8*k +: 8];
                end
            end
        end
    endtask

    always @(negedge clk) begin
        sb_step(0, rst_a, ifa.req, ifa.gnt, ifa.wen, ifa.add, ifa.be,
                ifa.data, ifa.r_valid, ifa.r_ready, ifa.r_data);
        sb_step(1, rst_b, ifb.req, ifb.gnt, ifb.wen, ifb.add, ifb.be,
                ifb.data, ifb.r_valid, ifb.r_ready, ifb.r_data);
        sb_step(2, rst_c, ifc.req, ifc.gnt, ifc.wen, ifc.add, ifc.be,
                ifc.data, ifc.r_valid, ifc.r_ready, ifc.r_data);
    end

    // Reference stall generator from the documented seed and taps.
    always @(posedge clk) begin
        if (rst_c) ref_l <= 16'hACE1;
        else       ref_l <= {ref_l[0] ^ ref_l[2] ^ ref_l[3] ^ ref_l[5], ref_l[15:1]};
    end

    typedef struct {
        logic         wen;
        logic [31:0]  add;
        logic [15:0]  be;
        logic [127:0] wd;
        logic [127:0] exp;
    } vec_t;

    vec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int nd;
        int stalls;

        tv[0] = '{1'b0, 32'h50,   16'hFFFF,
                  128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, '0};
        tv[1] = '{1'b1, 32'h50,   16'h0000, '0,
                  128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
        tv[2] = '{1'b0, 32'h50,   16'h000F, 128'h11223344, '0};
        tv[3] = '{1'b1, 32'h50,   16'h0000, '0,
                  128'hDEADBEEF_01234567_89ABCDEF_11223344};
        tv[4] = '{1'b0, 32'h10,   16'hFFFF,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100, '0};
        tv[5] = '{1'b1, 32'h4010, 16'h0000, '0,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100};
        tv[6] = '{1'b1, 32'h5F,   16'h0000, '0,
                  128'hDEADBEEF_01234567_89ABCDEF_11223344};
        tv[7] = '{1'b0, 32'h20,   16'hFFFF, '0, '0};
        tv[8] = '{1'b0, 32'h20,   16'hF0F0, {128{1'b1}}, '0};
        tv[9] = '{1'b1, 32'h20,   16'h0000, '0,
                  128'hFFFFFFFF_00000000_FFFFFFFF_00000000};

        rsp_n = '{0, 0, 0};
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.req = 0; ifa.wen = 0; ifa.add = '0; ifa.be = '0; ifa.data = '0;
        ifb.req = 0; ifb.wen = 0; ifb.add = '0; ifb.be = '0; ifb.data = '0;
        ifc.req = 0; ifc.wen = 0; ifc.add = '0; ifc.be = '0; ifc.data = '0;
        ifa.r_ready = 1'b1;
        ifb.r_ready = 1'b0;
        ifc.r_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        chki("rst_a_gnt", int'(ifa.gnt), 0);
        chki("rst_a_rvalid", int'(ifa.r_valid), 0);
        chk("rst_a_rdata", ifa.r_data, '0);
        chki("rst_a_outstanding", int'(out_a), 0);
        chki("rst_b_rvalid", int'(ifb.r_valid), 0);
        chki("rst_b_outstanding", int'(out_b), 0);

        // Table: one request per cycle, read data due one cycle later.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ifa.req  = 1'b1;
            ifa.wen  = tv[i].wen;
            ifa.add  = tv[i].add;
            ifa.be   = tv[i].be;
            ifa.data = tv[i].wd;
            @(negedge clk);
            chki($sformatf("a_gnt[%0d]", i), int'(ifa.gnt), 1);
            if (i > 0 && tv[i-1].wen) begin
                chki($sformatf("a_rvalid[%0d]", i), int'(ifa.r_valid), 1);
                chk($sformatf("a_rdata[%0d]", i), ifa.r_data, tv[i-1].exp);
            end else begin
                chki($sformatf("a_rvalid_idle[%0d]", i), int'(ifa.r_valid), 0);
            end
        end
        @(posedge clk); #1;
        ifa.req = 1'b0;
        @(negedge clk);
        chki("a_rvalid_last", int'(ifa.r_valid), 1);
        chk("a_rdata_last", ifa.r_data, tv[9].exp);
        @(negedge clk);
        chki("a_rvalid_drained", int'(ifa.r_valid), 0);
        chki("a_outstanding_drained", int'(out_a), 0);

        // LATENCY=3: fill credits with r_ready low, then release.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ifb.req  = 1'b1;
            ifb.wen  = 1'b0;
            ifb.add  = 32'(i * 16);
            ifb.be   = '1;
            ifb.data = {4{32'hB000_0000 + 32'(i)}};
            @(negedge clk);
            chki("b_wr_gnt", int'(ifb.gnt), 1);
        end
        ng = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            ifb.wen = 1'b1;
            ifb.add = 32'(ng * 16);
            @(negedge clk);
            if (ifb.gnt) ng++;
        end
        chki("b_grants_full", ng, 4);
        chki("b_outstanding_full", int'(out_b), 4);
        @(posedge clk); #1;
        ifb.wen  = 1'b0;
        ifb.add  = 32'h90;
        ifb.data = {4{32'hB000_0099}};
        @(negedge clk);
        chki("b_wr_gnt_full", int'(ifb.gnt), 1);
        @(posedge clk); #1;
        ifb.wen     = 1'b1;
        ifb.add     = 32'(ng * 16);
        ifb.r_ready = 1'b1;
        @(negedge clk);
        chki("b_gnt_pop_cycle", int'(ifb.gnt), 0);
        chki("b_rvalid_head", int'(ifb.r_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chki("b_gnt_after_pop", int'(ifb.gnt), 1);
        if (ifb.gnt) ng++;
        for (int k = 0; k < 40 && ng < 8; k++) begin
            @(posedge clk); #1;
            ifb.add = 32'(ng * 16);
            @(negedge clk);
            if (ifb.gnt) ng++;
        end
        @(posedge clk); #1;
        ifb.req = 1'b0;
        chki("b_grants_total", ng, 8);
        repeat (12) @(negedge clk);
        chki("b_responses", rsp_n[1], 8);
        chki("b_outstanding_idle", int'(out_b), 0);

        // Reset with three reads still in flight.
        ifb.r_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ifb.req = 1'b1;
            ifb.wen = 1'b1;
            ifb.add = 32'(i * 16);
            @(negedge clk);
            chki("b_inflight_gnt", int'(ifb.gnt), 1);
        end
        @(posedge clk); #1;
        ifb.req = 1'b0;
        rst_b   = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        chki("b_rst_rvalid", int'(ifb.r_valid), 0);
        chki("b_rst_outstanding", int'(out_b), 0);
        repeat (4) @(negedge clk);
        chki("b_rst_no_stale", int'(ifb.r_valid), 0);
        @(posedge clk); #1;
        ifb.r_ready = 1'b1;
        ifb.req     = 1'b1;
        ifb.add     = 32'h30;
        @(negedge clk);
        chki("b_post_rst_gnt", int'(ifb.gnt), 1);
        @(posedge clk); #1;
        ifb.req = 1'b0;
        for (int k = 0; k < 10 && !ifb.r_valid; k++) @(negedge clk);
        chki("b_post_rst_rvalid", int'(ifb.r_valid), 1);
        chk("b_post_rst_rdata", ifb.r_data, {4{32'hB000_0003}});

        // Stall-enabled: grant must follow the reference LFSR bit 0.
        nd = 0;
        stalls = 0;
        for (int k = 0; k < 400 && nd < 64; k++) begin
            @(posedge clk); #1;
            ifc.req  = 1'b1;
            ifc.wen  = 1'b0;
            ifc.be   = '1;
            ifc.add  = 32'(nd * 16);
            ifc.data = {4{32'hC000_0000 + 32'(nd)}};
            @(negedge clk);
            chki("c_wr_gnt_lfsr", int'(ifc.gnt), int'(!ref_l[0]));
            if (ifc.gnt) nd++;
            else stalls++;
        end
        chki("c_writes_done", nd, 64);
        nd = 0;
        for (int k = 0; k < 400 && nd < 64; k++) begin
            @(posedge clk); #1;
            ifc.wen = 1'b1;
            ifc.add = 32'(nd * 16);
            @(negedge clk);
            chki("c_rd_gnt_lfsr", int'(ifc.gnt), int'(!ref_l[0]));
            if (ifc.gnt) nd++;
            else stalls++;
        end
        @(posedge clk); #1;
        ifc.req = 1'b0;
        chki("c_reads_done", nd, 64);
        chki("c_stalls_seen", int'(stalls > 0), 1);
        repeat (8) @(negedge clk);
        chki("c_responses", rsp_n[2], 64);

        chki("a_sb_empty", q0.size(), 0);
        chki("b_sb_empty", q1.size(), 0);
        chki("c_sb_empty", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
